multicycle_sequencer: RTL and testbench

Control FSM for the multicycle variant of the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and issues the per-cycle write enables (PC, IR, register file, data memory) that the combinational control unit cannot time on its own. It also owns the memory request handshake, halts on ECALL or illegal opcodes, and counts retired instructions.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/opclass_decode.sv | 32 +++
 rtl/multicycle_sequencer.sv | 144 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
package riscv_pkg;

  // Sequencer state encodings; values are visible on the debug State port.
  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode classifier: exactly one class flag is high for any opcode.
module opclass_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_wb_o,
  output logic       is_system_o,
  output logic       is_illegal_o
);

  // Map the opcode onto its sequencing class; anything unrecognised is illegal.
  always_comb begin
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_branch_o  = 1'b0;
    is_wb_o      = 1'b0;
    is_system_o  = 1'b0;
    is_illegal_o = 1'b0;
    unique case (opcode_i)
      OP_LOAD:   is_load_o   = 1'b1;
      OP_STORE:  is_store_o  = 1'b1;
      OP_BRANCH: is_branch_o = 1'b1;
      OP_SYSTEM: is_system_o = 1'b1;
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_wb_o = 1'b1;
      default:   is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control FSM: steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, owns the
// memory request handshake, halts on ECALL or illegal opcodes, counts retired instructions.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       OpCode,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RUWrEn,
  output logic             DMWrEn,
  output logic             Halted,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Retired
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;

  logic mem_req, ir_wr, pc_wr, ru_wr_en, dm_wr_en, halted, set_illegal;
  logic is_load, is_store, is_branch, is_wb, is_system, is_illegal;

  opclass_decode u_opclass_decode (
    .opcode_i     (OpCode),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_branch_o  (is_branch),
    .is_wb_o      (is_wb),
    .is_system_o  (is_system),
    .is_illegal_o (is_illegal)
  );

  // Next-state and raw per-state enables; all defaults low.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    ru_wr_en    = 1'b0;
    dm_wr_en    = 1'b0;
    halted      = 1'b0;
    set_illegal = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (MemReady) begin
          ir_wr   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_system) begin
          state_d = StHalt;
        end else if (is_illegal) begin
          state_d     = StHalt;
          set_illegal = 1'b1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (is_load || is_store) begin
          state_d = StMemory;
        end else if (is_branch) begin
          pc_wr   = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        mem_req  = 1'b1;
        // Store qualifier is held for the whole access, not just the completion cycle.
        dm_wr_en = is_store;
        if (MemReady) begin
          if (is_store) begin
            pc_wr   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        ru_wr_en = 1'b1;
        pc_wr    = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State register, retired counter and sticky illegal flag; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_wr) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Every output is forced low while rst is high so an abandoned access issues nothing.
  always_comb begin
    MemReq  = mem_req  & ~rst;
    IRWr    = ir_wr    & ~rst;
    PCWr    = pc_wr    & ~rst;
    RUWrEn  = ru_wr_en & ~rst;
    DMWrEn  = dm_wr_en & ~rst;
    Halted  = halted   & ~rst;
    Illegal = illegal_q & ~rst;
    State   = rst ? 3'd0 : state_q;
    Retired = rst ? '0 : retired_q;
  end

  // IRWr and PCWr must never coincide.
  a_ir_pc_excl: assert property (@(posedge clk) !(IRWr && PCWr));
  // Classifier is one-hot for every opcode.
  a_class_onehot: assert property (@(posedge clk)
    $onehot({is_load, is_store, is_branch, is_wb, is_system, is_illegal}));
  // No side effects while in reset.
  a_rst_quiet: assert property (@(posedge clk)
    rst |-> !(MemReq || IRWr || PCWr || RUWrEn || DMWrEn));

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: directed table, hand-written corner sequences and random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    OpCode = 7'd0;
  logic          MemReady = 1'b0;
  logic          MemReq, IRWr, PCWr, RUWrEn, DMWrEn, Halted, Illegal;
  logic [2:0]    State;
  logic [CW-1:0] Retired;

  multicycle_sequencer #(.CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .OpCode   (OpCode),
    .MemReady (MemReady),
    .MemReq   (MemReq),
    .IRWr     (IRWr),
    .PCWr     (PCWr),
    .RUWrEn   (RUWrEn),
    .DMWrEn   (DMWrEn),
    .Halted   (Halted),
    .Illegal  (Illegal),
    .State    (State),
    .Retired  (Retired)
  );

  always #5 clk = ~clk;

  // Expected outputs; ctl order: memreq irwr pcwr ruwren dmwren halted illegal.
  typedef struct packed {
    logic [2:0] state;
    logic [6:0] ctl;
    logic [3:0] retired;
  } exp_t;

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic       rdy;
    exp_t       e;
  } vec_t;

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JR  = 7'b1100111;
  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_SYS = 7'b1110011;

  logic [6:0] legal_ops [9] = '{O_R, O_I, O_LD, O_ST, O_BR, O_JAL, O_JR, O_LUI, O_AUI};

  int n_cmp = 0;
  int n_bad = 0;
  int model_ret = 0;
  bit model_ill = 1'b0;

  function automatic exp_t ev(int st, logic [6:0] ctl, int ret);
    exp_t e;
    e.state   = 3'(st);
    e.ctl     = ctl;
    e.retired = 4'(ret);
    return e;
  endfunction

  // Expected record built from the instruction model's retired count and illegal flag.
  function automatic exp_t mk(int st, bit mr, bit ir, bit pc, bit ru, bit dm, bit h);
    return ev(st, {mr, ir, pc, ru, dm, h, model_ill}, model_ret % 16);
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic [6:0] op, input logic rdy, input exp_t e,
                      input string nm);
    exp_t a;
    @(negedge clk);
    rst      = r;
    OpCode   = op;
    MemReady = rdy;
    #1;
    a = {State, MemReq, IRWr, PCWr, RUWrEn, DMWrEn, Halted, Illegal, Retired};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
               nm, a.state, a.ctl, a.retired, e.state, e.ctl, e.retired);
    end
  endtask

  task automatic do_reset(input string nm);
    model_ret = 0;
    model_ill = 1'b0;
    step(1'b1, 7'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0), nm);
    step(1'b1, O_ST, 1'b1, mk(0, 0, 0, 0, 0, 0, 0), nm);
  endtask

  // One instruction: fw fetch waits, mw data waits, nh cycles checked if it halts.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int nh,
                           input string nm, output bit h);
    bit rdy;
    bit ld, st, br;
    h  = 1'b0;
    ld = (op == O_LD);
    st = (op == O_ST);
    br = (op == O_BR);
    for (int i = 0; i <= fw; i++) begin
      rdy = (i == fw);
      step(1'b0, 7'($urandom), rdy, mk(0, 1, rdy, 0, 0, 0, 0), {nm, "/fetch"});
    end
    step(1'b0, op, 1'($urandom), mk(1, 0, 0, 0, 0, 0, 0), {nm, "/decode"});
    if (op == O_SYS || !is_legal(op)) begin
      if (op != O_SYS) model_ill = 1'b1;
      h = 1'b1;
      for (int k = 0; k < nh; k++)
        step(1'b0, op, 1'($urandom), mk(5, 0, 0, 0, 0, 0, 1), {nm, "/halt"});
      return;
    end
    step(1'b0, op, 1'($urandom), mk(2, 0, 0, br, 0, 0, 0), {nm, "/exec"});
    if (br) begin
      model_ret++;
      return;
    end
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        rdy = (i == mw);
        step(1'b0, op, rdy, mk(3, 1, 0, st && rdy, 0, st, 0), {nm, "/mem"});
      end
      if (st) begin
        model_ret++;
        return;
      end
    end
    step(1'b0, op, 1'($urandom), mk(4, 0, 0, 1, 1, 0, 0), {nm, "/wb"});
    model_ret++;
  endtask

  initial begin
    vec_t tbl[9];
    bit   h;
    logic [6:0] op;
    int   r;

    // Reset then an R-type with memory always ready: states 0,1,2,4,0.
    tbl[0] = '{1'b1, O_R, 1'b1, ev(0, 7'b0000000, 0)};
    tbl[1] = '{1'b1, O_R, 1'b1, ev(0, 7'b0000000, 0)};
    tbl[2] = '{1'b0, O_R, 1'b1, ev(0, 7'b1100000, 0)};
    tbl[3] = '{1'b0, O_R, 1'b0, ev(1, 7'b0000000, 0)};
    tbl[4] = '{1'b0, O_R, 1'b1, ev(2, 7'b0000000, 0)};
    tbl[5] = '{1'b0, O_R, 1'b1, ev(4, 7'b0011000, 0)};
    tbl[6] = '{1'b0, O_R, 1'b0, ev(0, 7'b1000000, 1)};
    tbl[7] = '{1'b0, O_R, 1'b1, ev(0, 7'b1100000, 1)};
    tbl[8] = '{1'b0, O_R, 1'b0, ev(1, 7'b0000000, 1)};
    for (int i = 0; i < 9; i++) step(tbl[i].r, tbl[i].op, tbl[i].rdy, tbl[i].e, "table_rtype");

    // Load with two data wait cycles: 7 cycles to retire.
    do_reset("rst_load");
    run_instr(O_LD, 0, 2, 0, "load_wait2", h);
    step(1'b0, O_R, 1'b0, mk(0, 1, 0, 0, 0, 0, 0), "load_retired");

    // Store with waits: DMWrEn through MEMORY, PCWr only on the ready cycle.
    do_reset("rst_store");
    run_instr(O_ST, 1, 3, 0, "store_wait3", h);

    // Illegal opcode halts for good; MemReq stays low.
    do_reset("rst_illegal");
    run_instr(7'b0000000, 0, 0, 20, "illegal", h);
    do_reset("rst_after_halt");
    step(1'b0, O_R, 1'b0, mk(0, 1, 0, 0, 0, 0, 0), "fetch_after_halt");

    // ECALL halts without Illegal.
    do_reset("rst_ecall");
    run_instr(O_SYS, 0, 0, 5, "ecall", h);

    // Reset during the data wait of a store abandons it.
    do_reset("rst_abandon");
    run_instr(O_I, 0, 0, 0, "pre_alu", h);
    step(1'b0, O_ST, 1'b1, mk(0, 1, 1, 0, 0, 0, 0), "abandon/fetch");
    step(1'b0, O_ST, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "abandon/decode");
    step(1'b0, O_ST, 1'b1, mk(2, 0, 0, 0, 0, 0, 0), "abandon/exec");
    step(1'b0, O_ST, 1'b0, mk(3, 1, 0, 0, 0, 1, 0), "abandon/mem_wait");
    step(1'b0, O_ST, 1'b0, mk(3, 1, 0, 0, 0, 1, 0), "abandon/mem_wait");
    model_ret = 0;
    step(1'b1, O_ST, 1'b1, mk(0, 0, 0, 0, 0, 0, 0), "abandon/in_rst");
    step(1'b0, O_ST, 1'b0, mk(0, 1, 0, 0, 0, 0, 0), "abandon/released");

    // Sixteen branches wrap the 4-bit counter.
    do_reset("rst_wrap");
    for (int i = 0; i < 16; i++) run_instr(O_BR, 0, 0, 0, "branch", h);
    step(1'b0, O_BR, 1'b0, mk(0, 1, 0, 0, 0, 0, 0), "wrap_to_zero");

    // Random instruction stream with random wait states.
    do_reset("rst_random");
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      op = 7'($urandom);
      else if (r == 1) op = O_SYS;
      else             op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 3, "random", h);
      if (h) do_reset("rst_random_halt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
